// File: rtl/crypt3_bin2ascii_serializer.sv
// Recovers the 7-bit characters from a crypt(3) PC1-layout key word and streams them
// out as ASCII bytes, stopping at the first NUL.
module crypt3_bin2ascii_serializer (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic [63:0] din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic [55:0] key56,
    output logic [3:0]  len,
    output logic        parity_err
);

    typedef enum logic {StIdle, StSend} state_t;

    state_t      state_q, state_d;
    logic [2:0]  index_q, index_d;
    logic [55:0] key_q;
    logic [3:0]  len_q;
    logic        perr_q;
    logic        alive_q;

    logic [55:0] dec_key;
    logic [3:0]  dec_len;
    logic        dec_perr;
    logic        accept;
    logic        last_byte;
    logic [5:0]  bit_base;
    logic [6:0]  cur_char;

    // Each input byte holds its character bit-reversed in bits 6..0; bit 7 is parity only.
    always_comb begin
        dec_key  = '0;
        dec_perr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            dec_perr = dec_perr | din[8*k+7];
            for (int i = 0; i < 7; i++) begin
                dec_key[7*k+i] = din[8*k+6-i];
            end
        end
        // Scanning downward leaves the lowest NUL position in dec_len.
        dec_len = 4'd8;
        for (int k = 7; k >= 0; k--) begin
            if (dec_key[7*k +: 7] == 7'd0) begin
                dec_len = 4'(k);
            end
        end
    end

    assign bit_base  = 6'(index_q) * 6'd7;
    assign cur_char  = key_q[bit_base +: 7];
    assign last_byte = (len_q == 4'd0) || ({1'b0, index_q} == len_q - 4'd1);
    assign accept    = (state_q == StIdle) && alive_q && din_valid;

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout       = 8'h00;
        dout_last  = 1'b0;
        unique case (state_q)
            StIdle: begin
                din_ready = alive_q;
                if (accept) begin
                    state_d = StSend;
                    index_d = 3'd0;
                end
            end
            StSend: begin
                dout_valid = 1'b1;
                dout       = {1'b0, cur_char};
                dout_last  = last_byte;
                if (dout_ready) begin
                    if (last_byte) begin
                        state_d = StIdle;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            index_q <= 3'd0;
            key_q   <= '0;
            len_q   <= 4'd0;
            perr_q  <= 1'b0;
            alive_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            alive_q <= 1'b1;
            if (accept) begin
                key_q  <= dec_key;
                len_q  <= dec_len;
                perr_q <= dec_perr;
            end
        end
    end

    assign key56      = key_q;
    assign len        = len_q;
    assign parity_err = perr_q;

endmodule

// File: tb/tb_crypt3_bin2ascii_serializer.sv
// Scoreboard bench: expected bytes are queued when a word is offered and popped as the
// serializer transfers them.
module tb_crypt3_bin2ascii_serializer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_last;
    logic [55:0] key56;
    logic [3:0]  len;
    logic        parity_err;

    crypt3_bin2ascii_serializer dut (
        .CLK        (clk),
        .reset_n    (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .key56      (key56),
        .len        (len),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];
    int         ready_mode;
    int         nbytes;
    int         cyc = 0;
    logic       accepted;
    logic       prev_stall;
    logic [8:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: the inverse of the character decode.
    function automatic logic [63:0] a2b(input logic [55:0] key, input logic [7:0] par);
        logic [63:0] d;
        for (int k = 0; k < 8; k++) begin
            d[8*k+7] = par[k];
            for (int i = 0; i < 7; i++) d[8*k+6-i] = key[7*k+i];
        end
        return d;
    endfunction

    function automatic int exp_len(input logic [55:0] key);
        for (int k = 0; k < 8; k++) if (key[7*k +: 7] == 7'd0) return k;
        return 8;
    endfunction

    function automatic logic [55:0] str2key(input string s);
        logic [55:0] key = '0;
        byte         c;
        for (int k = 0; k < s.len() && k < 8; k++) begin
            c = s[k];
            key[7*k +: 7] = c[6:0];
        end
        return key;
    endfunction

    task automatic step();
        logic [8:0] e;
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = (cyc % 2 == 0);
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
        if (prev_stall) check("stall_hold", {dout_valid, dout_last, dout}, {1'b1, held});
        if (din_valid && din_ready) accepted = 1'b1;
        if (dout_valid && dout_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_byte", 64'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                check("byte", {dout_last, dout}, e);
            end
            nbytes++;
            if (dout_last) din_valid = 1'b0;
        end
        prev_stall = dout_valid && !dout_ready;
        held       = {dout_last, dout};
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [55:0] key, input logic [7:0] par, input int mode,
                             input int abort_after);
        int l = exp_len(key);
        int guard;
        ready_mode = mode;
        nbytes     = 0;
        accepted   = 1'b0;
        prev_stall = 1'b0;
        if (l == 0) exp_q.push_back(9'h100);
        else for (int k = 0; k < l; k++) exp_q.push_back({k == l - 1, 1'b0, key[7*k +: 7]});
        din       = a2b(key, par);
        din_valid = 1'b1;
        guard     = 0;
        while (!accepted && guard < 20) begin
            step();
            guard++;
        end
        check("accepted", 64'(accepted), 1);
        // Garbage offered while busy must be ignored.
        din = {$urandom, $urandom};
        check("first_valid", 64'(dout_valid), 1);
        check("din_ready_busy", 64'(din_ready), 0);
        check("key56", key56, key);
        check("len", 64'(len), 64'(l));
        check("parity_err", 64'(parity_err), 64'(|par));
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            if (abort_after > 0 && nbytes == abort_after) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(dout_valid), 0);
                check("abort_ready", 64'(din_ready), 0);
                check("abort_key", key56, 0);
                exp_q.delete();
                din_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            step();
            guard++;
        end
        check("drained", 64'(exp_q.size()), 0);
        if (mode == 0) check("cycles", 64'(guard), 64'((l == 0) ? 1 : l));
        check("idle_ready", 64'(din_ready), 1);
        check("idle_valid", 64'(dout_valid), 0);
        check("key_held", key56, key);
        check("len_held", 64'(len), 64'(l));
    endtask

    initial begin
        logic [55:0] rk;
        rst_n      = 1'b0;
        din        = '0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        ready_mode = 0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(din_ready), 0);
        check("rst_valid", 64'(dout_valid), 0);
        check("rst_dout", 64'(dout), 0);
        check("rst_last", 64'(dout_last), 0);
        check("rst_key", key56, 0);
        check("rst_len", 64'(len), 0);
        check("rst_perr", 64'(parity_err), 0);
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", 64'(din_ready), 0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 64'(din_ready), 1);

        send_word(str2key("password"), 8'h00, 0, 0);
        send_word(str2key("abc"), 8'h00, 1, 0);
        send_word(56'h0, 8'h00, 0, 0);
        send_word(str2key("A"), 8'h81, 0, 0);
        check("parity_din", a2b(str2key("A"), 8'h81),
              a2b(str2key("A"), 8'h00) | 64'h8000_0000_0000_0080);
        send_word(str2key("ab") | (str2key("cd") << 21), 8'h00, 0, 0);
        send_word(str2key("password"), 8'h00, 0, 3);
        send_word(str2key("zebra"), 8'h10, 0, 0);

        for (int w = 0; w < 300; w++) begin
            rk = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) if ($urandom_range(0, 3) == 0) rk[7*k +: 7] = 7'd0;
            send_word(rk, 8'($urandom), 2, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
